// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID/EX stall, flush and bubble control for load-use, MDU and redirect hazards.
// Ports:
//   clock, reset            pipeline clock (falling-edge state updates), sync active-low reset
//   ifid_*                  source/usage decode of the instruction sitting in IF/ID
//   MemRead_pipe_id, idex_rt  load flag and destination of the instruction in ID/EX
//   ex_branch_taken, ex_jump  PC redirect resolved in EX
//   pc_write, ifid_write    PC / IF/ID load enables
//   ifid_flush, idex_bubble squash IF/ID, insert bubble into ID/EX
//   mdu_busy                multiply/divide unit occupied
//   stall_count             saturating count of stall cycles
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 3,
    parameter int PERF_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              ifid_uses_rs,
    input  logic              ifid_uses_rt,
    input  logic              ifid_is_mdu,
    input  logic              ifid_reads_hilo,
    input  logic              MemRead_pipe_id,
    input  logic [4:0]        idex_rt,
    input  logic              ex_branch_taken,
    input  logic              ex_jump,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_count
);
    typedef enum logic {RUN, MDU_BUSY} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  perf_q, perf_d;
    logic               redirect, load_use, mdu_hz, hazard, issue;
    always_comb begin
        redirect = ex_branch_taken | ex_jump;
        load_use = MemRead_pipe_id & (idex_rt != 5'd0) &
                   ((ifid_uses_rs & (ifid_rs == idex_rt)) | (ifid_uses_rt & (ifid_rt == idex_rt)));
        mdu_hz   = (state_q == MDU_BUSY) & (ifid_is_mdu | ifid_reads_hilo);
        hazard   = load_use | mdu_hz;
        // a squashed IF/ID instruction must never start the MDU
        issue    = ifid_is_mdu & ~redirect & ~hazard;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (state_q == RUN) begin
            if (issue) begin
                state_d = MDU_BUSY;
                cnt_d   = CNT_W'(MDU_LATENCY);
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        perf_d = (hazard & ~redirect & ~&perf_q) ? perf_q + 1'b1 : perf_q;
    end
    always_ff @(negedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end
    // reset forces a flushing, bubbling, free-running pipeline front end
    assign pc_write    = ~reset | redirect | ~hazard;
    assign ifid_write  = ~reset | redirect | ~hazard;
    assign ifid_flush  = ~reset | redirect;
    assign idex_bubble = ~reset | redirect | hazard;
    assign mdu_busy    = reset & (state_q == MDU_BUSY);
    assign stall_count = perf_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table-driven and sequenced checks of hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        ifid_uses_rs, ifid_uses_rt, ifid_is_mdu, ifid_reads_hilo;
    logic        MemRead_pipe_id, ex_branch_taken, ex_jump;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy;
    logic [15:0] stall_count;
    logic        pc4, ifw4, fl4, bub4, busy4;
    logic [3:0]  stall4;
    int          checks = 0;
    int          failures = 0;
    int          exp_perf = 0;

    always #5 clock = ~clock;

    hazard_stall_ctrl dut (
        .clock(clock), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .ifid_is_mdu(ifid_is_mdu),
        .ifid_reads_hilo(ifid_reads_hilo), .MemRead_pipe_id(MemRead_pipe_id), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    hazard_stall_ctrl #(.PERF_W(4)) dut4 (
        .clock(clock), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .ifid_is_mdu(ifid_is_mdu),
        .ifid_reads_hilo(ifid_reads_hilo), .MemRead_pipe_id(MemRead_pipe_id), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .pc_write(pc4),
        .ifid_write(ifw4), .ifid_flush(fl4), .idex_bubble(bub4),
        .mdu_busy(busy4), .stall_count(stall4)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt, xrt;
        logic       urs, urt, mdu, hilo, memrd, br, jmp;
        logic       e_pc, e_ifw, e_fl, e_bub;
        int         inc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0;
        ifid_uses_rs = 0; ifid_uses_rt = 0; ifid_is_mdu = 0; ifid_reads_hilo = 0;
        MemRead_pipe_id = 0; ex_branch_taken = 0; ex_jump = 0;
    endtask

    // commit the current inputs at the falling edge and return to a quiet sample point
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk_out(input string name, input logic p, input logic w, input logic f, input logic b);
        #2;
        chk({name, ".pc_write"}, 32'(pc_write), 32'(p));
        chk({name, ".ifid_write"}, 32'(ifid_write), 32'(w));
        chk({name, ".ifid_flush"}, 32'(ifid_flush), 32'(f));
        chk({name, ".idex_bubble"}, 32'(idex_bubble), 32'(b));
    endtask

    task automatic load_use_on();
        quiet();
        MemRead_pipe_id = 1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_uses_rs = 1;
    endtask

    initial begin
        //          name        rs  rt  xrt urs urt mdu hilo mem br jmp  pc ifw fl bub inc
        vecs[0] = '{"quiet",     1,  2,  3,  1,  1,  0,  0,  0,  0,  0,  1,  1, 0, 0, 0};
        vecs[1] = '{"lu_rs",     8,  2,  8,  1,  0,  0,  0,  1,  0,  0,  0,  0, 0, 1, 1};
        vecs[2] = '{"lu_rt",     4,  9,  9,  0,  1,  0,  0,  1,  0,  0,  0,  0, 0, 1, 1};
        vecs[3] = '{"lu_r0",     0,  0,  0,  1,  1,  0,  0,  1,  0,  0,  1,  1, 0, 0, 0};
        vecs[4] = '{"lu_unused", 8,  8,  8,  0,  0,  0,  0,  1,  0,  0,  1,  1, 0, 0, 0};
        vecs[5] = '{"no_load",   8,  8,  8,  1,  1,  0,  0,  0,  0,  0,  1,  1, 0, 0, 0};
        vecs[6] = '{"branch",    1,  2,  3,  0,  0,  0,  0,  0,  1,  0,  1,  1, 1, 1, 0};
        vecs[7] = '{"jmp_lu_md", 8,  2,  8,  1,  0,  1,  0,  1,  0,  1,  1,  1, 1, 1, 0};
        vecs[8] = '{"br_lu_mdu",31,  2, 31,  1,  0,  1,  0,  1,  1,  0,  1,  1, 1, 1, 0};
        vecs[9] = '{"hilo_idle", 1,  2,  3,  0,  0,  0,  1,  0,  0,  0,  1,  1, 0, 0, 0};

        // reset with random inputs: outputs forced, state cleared
        reset = 0;
        for (int c = 0; c < 2; c++) begin
            {ifid_rs, ifid_rt, idex_rt} = 15'($urandom);
            {ifid_uses_rs, ifid_uses_rt, ifid_is_mdu, ifid_reads_hilo, MemRead_pipe_id,
             ex_branch_taken, ex_jump} = 7'($urandom);
            #1;
            chk_out("rst", 1, 1, 1, 1);
            chk("rst.mdu_busy", 32'(mdu_busy), 0);
            if (c == 1) chk("rst.stall_count", 32'(stall_count), 0);
            tick();
        end
        reset = 1;
        quiet();
        chk_out("post_rst", 1, 1, 0, 0);
        chk("post_rst.stall_count", 32'(stall_count), 0);
        tick();

        // single-cycle vectors in RUN; none may start the MDU
        foreach (vecs[i]) begin
            quiet();
            ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt; idex_rt = vecs[i].xrt;
            ifid_uses_rs = vecs[i].urs; ifid_uses_rt = vecs[i].urt;
            ifid_is_mdu = vecs[i].mdu; ifid_reads_hilo = vecs[i].hilo;
            MemRead_pipe_id = vecs[i].memrd; ex_branch_taken = vecs[i].br; ex_jump = vecs[i].jmp;
            chk_out(vecs[i].name, vecs[i].e_pc, vecs[i].e_ifw, vecs[i].e_fl, vecs[i].e_bub);
            chk({vecs[i].name, ".mdu_busy"}, 32'(mdu_busy), 0);
            chk({vecs[i].name, ".stall_count"}, 32'(stall_count), 32'(exp_perf));
            tick();
            exp_perf += vecs[i].inc;
        end
        quiet();
        #2;
        chk("table.mdu_busy", 32'(mdu_busy), 0);
        chk("table.stall_count", 32'(stall_count), 32'(exp_perf));

        // load-use lasts one cycle once the load leaves ID/EX
        load_use_on();
        chk_out("lu_seq0", 0, 0, 0, 1);
        tick();
        exp_perf++;
        quiet();
        ifid_rs = 5'd8; ifid_uses_rs = 1;
        chk_out("lu_seq1", 1, 1, 0, 0);
        chk("lu_seq.stall_count", 32'(stall_count), 32'(exp_perf));
        tick();

        // mult issues, mfhi waits the full window then advances
        quiet();
        ifid_is_mdu = 1;
        chk_out("mult_issue", 1, 1, 0, 0);
        tick();
        quiet();
        ifid_reads_hilo = 1;
        for (int c = 0; c < 4; c++) begin
            chk_out($sformatf("mfhi_wait%0d", c), 0, 0, 0, 1);
            chk($sformatf("mfhi_wait%0d.mdu_busy", c), 32'(mdu_busy), 1);
            tick();
            exp_perf++;
        end
        chk_out("mfhi_go", 1, 1, 0, 0);
        chk("mfhi_go.mdu_busy", 32'(mdu_busy), 0);
        chk("mfhi_go.stall_count", 32'(stall_count), 32'(exp_perf));
        tick();

        // redirect during the window drops the stall but not the countdown
        quiet();
        ifid_is_mdu = 1;
        tick();
        quiet();
        ifid_reads_hilo = 1; ex_branch_taken = 1;
        chk_out("busy_redirect", 1, 1, 1, 1);
        tick();
        quiet();
        for (int c = 1; c < 4; c++) begin
            #2;
            chk($sformatf("busy_cont%0d", c), 32'(mdu_busy), 1);
            tick();
        end
        #2;
        chk("busy_end", 32'(mdu_busy), 0);
        chk("busy_redirect.stall_count", 32'(stall_count), 32'(exp_perf));

        // reset two cycles after issue abandons the op
        quiet();
        ifid_is_mdu = 1;
        tick();
        quiet();
        tick();
        reset = 0;
        #2;
        chk("mid_rst.mdu_busy", 32'(mdu_busy), 0);
        tick();
        reset = 1;
        exp_perf = 0;
        ifid_reads_hilo = 1;
        chk_out("mid_rst_mfhi", 1, 1, 0, 0);
        chk("mid_rst.mdu_busy_after", 32'(mdu_busy), 0);
        chk("mid_rst.stall_count", 32'(stall_count), 0);
        tick();

        // 2^4+3 consecutive stalls saturate the narrow counter at 15
        load_use_on();
        for (int c = 0; c < 19; c++) begin
            tick();
            exp_perf++;
        end
        quiet();
        #2;
        chk("sat.stall4", 32'(stall4), 15);
        chk("sat.stall16", 32'(stall_count), 32'(exp_perf));
        load_use_on();
        tick();
        quiet();
        #2;
        chk("sat_hold.stall4", 32'(stall4), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
